// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores on the data-memory bus,
// stalls upstream while a transaction is outstanding, registers the writeback result.
module mem_stage #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_write_data,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_reg_write,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_funct3,
  output logic        stall,
  output logic [31:0] bp_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_exc,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      cap_addr, cap_wdata;
  logic             cap_we, cap_reg_write;
  logic [4:0]       cap_rd;
  logic [2:0]       cap_funct3;

  logic        mem_op, misaligned, accept, complete, timed_out, busy;
  logic [1:0]  off;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign bp_mem = in_alu_result;

  always_comb begin
    mem_op     = in_valid & (in_mem_read | in_mem_write);
    misaligned = ((in_funct3[1:0] == 2'b01) && in_alu_result[0]) ||
                 ((in_funct3[1:0] == 2'b10) && (in_alu_result[1:0] != 2'b00));
    accept     = (state == IDLE) & mem_op & ~misaligned;
    busy       = (state == REQ) | (state == RESP);
    complete   = ((state == REQ) & cap_we & dmem_ready) | ((state == RESP) & dmem_rvalid);
    // completion takes precedence over an expiring counter in the same cycle
    timed_out  = busy & ~complete & (cnt == CNT_W'(TIMEOUT - 1));
    stall      = ~rst & (accept | (busy & ~complete & ~timed_out));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = REQ;
      REQ: begin
        if (complete || timed_out) state_nx = IDLE;
        else if (dmem_ready)       state_nx = RESP;
      end
      RESP: if (complete || timed_out) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    off = cap_addr[1:0];
    case (cap_funct3)
      3'b000: begin
        st_be    = 4'b0001 << off;
        st_wdata = {4{cap_wdata[7:0]}};
      end
      3'b001: begin
        st_be    = 4'b0011 << off;
        st_wdata = {2{cap_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = cap_wdata;
      end
    endcase
  end

  always_comb begin
    case (off)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (cap_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    dmem_req   = (state == REQ);
    dmem_we    = dmem_req & cap_we;
    dmem_addr  = dmem_req ? {cap_addr[31:2], 2'b00} : '0;
    dmem_wdata = dmem_req ? st_wdata : '0;
    dmem_be    = dmem_req ? st_be : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      cap_addr      <= '0;
      cap_wdata     <= '0;
      cap_we        <= 1'b0;
      cap_reg_write <= 1'b0;
      cap_rd        <= '0;
      cap_funct3    <= '0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      misalign_exc  <= 1'b0;
      bus_timeout   <= 1'b0;
    end else begin
      state        <= state_nx;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      misalign_exc <= 1'b0;
      bus_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && !mem_op) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= in_reg_write;
            wb_rd        <= in_rd;
            wb_data      <= in_alu_result;
          end else if (mem_op && misaligned) begin
            wb_valid     <= 1'b1;
            misalign_exc <= 1'b1;
            wb_rd        <= in_rd;
            wb_data      <= in_alu_result;
          end else if (accept) begin
            cnt           <= '0;
            cap_addr      <= in_alu_result;
            cap_wdata     <= in_write_data;
            cap_we        <= in_mem_write;
            cap_reg_write <= in_reg_write;
            cap_rd        <= in_rd;
            cap_funct3    <= in_funct3;
          end
        end
        REQ, RESP: begin
          cnt <= cnt + 1'b1;
          if (complete) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= ~cap_we & cap_reg_write;
            wb_rd        <= cap_rd;
            wb_data      <= cap_we ? cap_addr : ld_data;
          end else if (timed_out) begin
            wb_valid    <= 1'b1;
            bus_timeout <= 1'b1;
            wb_rd       <= cap_rd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. Sits directly downstream of the execute stage and upstream of writeback.
- Takes the execute stage's registered ALU result, store data, control bits and rd.
- Performs loads and stores over a request/ready/rvalid data-memory bus, stalling upstream while a bus transaction is outstanding.
- Registers the result into the writeback interface and drives the MEM-stage bypass value.

Parameters:
TIMEOUT, 64, max cycles spent in REQ+RESP before the access is aborted (>=2)
CNT_W, 7, width of the timeout counter; must hold TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  instruction present from execute
in_alu_result  in  32  address or ALU result
in_write_data  in  32  store data (rs2)
in_mem_read  in  1  load
in_mem_write  in  1  store
in_reg_write  in  1  instruction writes rd
in_rd  in  5  destination register
in_funct3  in  3  access size/sign
stall  out  1  hold execute/upstream stages this cycle
bp_mem  out  32  bypass value to execute (= in_alu_result, combinational)
dmem_req  out  1  bus request
dmem_we  out  1  1=store
dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ready  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  32  read data word
wb_valid  out  1  registered: result present for writeback
wb_reg_write  out  1  registered: write rd
wb_rd  out  5  registered destination
wb_data  out  32  registered result
misalign_exc  out  1  registered 1-cycle pulse, misaligned access
bus_timeout  out  1  registered 1-cycle pulse, aborted access

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0; all dmem_* and wb_* outputs, misalign_exc and bus_timeout are 0. Applies mid-transaction; dmem_req drops at once.
- Access classification:
  - mem_op = in_valid & (in_mem_read | in_mem_write).
  - mem_write has priority if both are set.
  - mem_read is qualified by in_valid here.
- Alignment: misaligned if funct3[1:0]=01 and addr[0]!=0, or funct3[1:0]=10 and addr[1:0]!=0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Non-mem valid op: at the next edge, wb_valid=1, wb_reg_write=in_reg_write, wb_rd=in_rd, wb_data=in_alu_result. Latency 1, stall=0.
  - Misaligned mem_op: no bus access. At the next edge, wb_valid=1, wb_reg_write=0, misalign_exc=1, stall=0.
  - Aligned mem_op: capture addr, we, rd, reg_write, funct3 and store data; go to REQ; stall=1; wb_valid=0 at the next edge.
  - in_valid=0: wb_valid=0.
- REQ:
  - Outputs: dmem_req=1, with dmem_we/addr/wdata/be driven from the captured op.
  - Store with dmem_ready: stall=0; go to IDLE; at the edge, wb_valid=1, wb_reg_write=0.
  - Load with dmem_ready: go to RESP; stall stays 1.
- RESP:
  - dmem_req=0.
  - On dmem_rvalid: stall=0; go to IDLE; at the edge, wb_valid=1, wb_reg_write=captured reg_write, wb_data=extended load data.
- stall is combinational: 1 when (IDLE & aligned mem_op) or (REQ/RESP & not completing this cycle).
  - Upstream holds its inputs while stall=1 and advances at the edge where stall=0.
  - Minimum latency: store 2 cycles, load 3 cycles.
- While stall=1, wb_valid=0 every cycle (bubble into writeback).
- Store encoding (byte offset o=addr[1:0]):
  - SB (000): be=0001<<o; wdata={4{data[7:0]}}.
  - SH (001): be=0011<<o; wdata={2{data[15:0]}}.
  - SW (010): be=1111; wdata=data.
  - Any other funct3 is treated as SW.
- Load extraction: select the byte or halfword lane by o.
  - LB (000) sign-extends the byte; LBU (100) zero-extends it.
  - LH (001) sign-extends the halfword; LHU (101) zero-extends it.
  - LW (010) and any other funct3 take the full word.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ/RESP.
  - When counter reaches TIMEOUT-1 without completion, go to IDLE and drop stall.
  - At that edge, wb_valid=1, wb_reg_write=0, bus_timeout=1.
- Completion and timeout in the same cycle: completion wins.
- dmem_rvalid in IDLE/REQ and dmem_ready in RESP/IDLE are ignored.

Test Plan:
- ALU op in_valid=1, reg_write=1, rd=5, alu_result=0x1234 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234; stall never asserted; bp_mem=0x1234 in the same cycle.
- SB addr=0x103, data=0xAB, dmem_ready=1 on the first REQ cycle:
  - Required: dmem_be=1000, dmem_addr=0x100, dmem_wdata=0xABABABAB.
  - stall high for 1 cycle; wb_valid=1 with wb_reg_write=0 two cycles after issue.
- LB addr=0x102, rd=7, dmem_ready after 2 cycles, rvalid with rdata=0x00800000 after 3 more -> wb_data=0xFFFFFF80, wb_rd=7; wb_valid=0 during the stall. Repeat as LBU -> wb_data=0x00000080.
- LW addr=0x22 -> no dmem_req; next cycle misalign_exc=1, wb_valid=1, wb_reg_write=0, stall=0.
- TIMEOUT=8, load with dmem_ready held 0 -> stall high for exactly 8 cycles, then bus_timeout pulse, wb_reg_write=0, FSM back in IDLE accepting the next op.
- rst asserted while in RESP -> dmem_req, wb_valid and stall drop immediately; after release a new LW at 0x40 completes normally.
